// File: rtl/instr_encoder_pkg.sv
// Shared ISA definitions for the instruction encoder/decoder pair.
// Holds the opcode map, the encoder error codes and the encoder FSM states.
// No ports; import with "import instr_encoder_pkg::*;".
package instr_encoder_pkg;

   // Opcode map, shared with the instruction decoder.
   localparam logic [3:0] OP_ADD    = 4'h0;
   localparam logic [3:0] OP_SUB    = 4'h1;
   localparam logic [3:0] OP_XOR    = 4'h2;
   localparam logic [3:0] OP_RED    = 4'h3;
   localparam logic [3:0] OP_SLL    = 4'h4;
   localparam logic [3:0] OP_SRA    = 4'h5;
   localparam logic [3:0] OP_ROR    = 4'h6;
   localparam logic [3:0] OP_PADDSB = 4'h7;
   localparam logic [3:0] OP_LW     = 4'h8;
   localparam logic [3:0] OP_SW     = 4'h9;
   localparam logic [3:0] OP_LLB    = 4'hA;
   localparam logic [3:0] OP_LHB    = 4'hB;
   localparam logic [3:0] OP_B      = 4'hC;
   localparam logic [3:0] OP_BR     = 4'hD;
   localparam logic [3:0] OP_PCS    = 4'hE;
   localparam logic [3:0] OP_HLT    = 4'hF;

   // err_code values.
   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_RANGE    = 2'd1;
   localparam logic [1:0] ERR_ALIGN    = 2'd2;
   localparam logic [1:0] ERR_OVERFLOW = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_DONE,
      ST_ERROR
   } enc_state_t;

   // True when v is representable as a signed number whose sign bit is v[msb],
   // i.e. every bit above msb is a copy of v[msb].
   function automatic logic fits_signed(input logic [15:0] v, input int msb);
      logic signed [15:0] sh;
      sh = $signed(v) >>> msb;
      return (sh == 16'sh0000) || (sh == 16'shFFFF);
   endfunction

endpackage

// File: rtl/instr_pack.sv
// Field-to-word packer: builds the 16-bit instruction word and range-checks the immediate.
// Latency: purely combinational. Backpressure: none, the caller owns the handshake.
// Ports: opcode/rd/rs/rt/imm/cond in; word (encoded instruction), err (err_code value, 0 = ok) out.
module instr_pack
   import instr_encoder_pkg::*;
(
   input  logic [3:0]  opcode,
   input  logic [3:0]  rd,
   input  logic [3:0]  rs,
   input  logic [3:0]  rt,
   input  logic [15:0] imm,
   input  logic [2:0]  cond,
   output logic [15:0] word,
   output logic [1:0]  err
);

   always_comb begin
      word = 16'h0000;
      err  = ERR_NONE;
      case (opcode)
         OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
            word = {opcode, rd, rs, rt};
         end
         OP_SLL, OP_SRA, OP_ROR: begin
            word = {opcode, rd, rs, imm[3:0]};
            if (imm[15:4] != 12'h000) err = ERR_RANGE;
         end
         OP_LW, OP_SW: begin
            // Offset is in bytes; the word field stores offset/2. SW names its data register rt.
            word = {opcode, (opcode == OP_SW) ? rt : rd, rs, imm[4:1]};
            if (imm[0])                     err = ERR_ALIGN;
            else if (!fits_signed(imm, 4))  err = ERR_RANGE;
         end
         OP_LLB, OP_LHB: begin
            word = {opcode, rd, imm[7:0]};
            if (imm[15:8] != 8'h00) err = ERR_RANGE;
         end
         OP_B: begin
            word = {opcode, cond, imm[9:1]};
            if (imm[0])                     err = ERR_ALIGN;
            else if (!fits_signed(imm, 9))  err = ERR_RANGE;
         end
         OP_BR: begin
            word = {opcode, cond, 1'b0, rs, 4'h0};
         end
         OP_PCS: begin
            word = {opcode, rd, 8'h00};
         end
         OP_HLT: begin
            word = {opcode, 12'h000};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes field bundles and streams the words into instruction memory from base_addr.
// Latency: word appears on imem_we one cycle after acceptance; one word/cycle sustained.
// Backpressure: single output register; in_ready drops while a write is stalled by imem_ready or HLT is pending.
// Ports: clk, rst (async, active-high); start/base_addr program control;
//        in_valid/in_ready + in_opcode/in_rd/in_rs/in_rt/in_imm/in_cond field bundle;
//        imem_we/imem_ready/imem_addr/imem_wdata memory write; done/error/err_code/word_count status.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int DEPTH_WORDS = 256
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] base_addr,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_opcode,
   input  logic [3:0]  in_rd,
   input  logic [3:0]  in_rs,
   input  logic [3:0]  in_rt,
   input  logic [15:0] in_imm,
   input  logic [2:0]  in_cond,
   output logic        imem_we,
   input  logic        imem_ready,
   output logic [15:0] imem_addr,
   output logic [15:0] imem_wdata,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code,
   output logic [15:0] word_count
);

   enc_state_t  state, state_nxt;
   logic        halt_pending;
   logic [16:0] acc_count;     // bundles accepted into the output register since start
   logic [15:0] pack_word;
   logic [1:0]  pack_err;
   logic [1:0]  bundle_err;
   logic        accept;
   logic        wr_hs;
   logic        overflow;
   logic        start_ok;

   instr_pack u_pack (
      .opcode (in_opcode),
      .rd     (in_rd),
      .rs     (in_rs),
      .rt     (in_rt),
      .imm    (in_imm),
      .cond   (in_cond),
      .word   (pack_word),
      .err    (pack_err)
   );

   assign in_ready = (state == ST_ACTIVE) && (!imem_we || imem_ready) && !halt_pending;
   assign accept   = in_valid && in_ready;
   assign wr_hs    = imem_we && imem_ready;
   assign overflow = (acc_count >= 17'(DEPTH_WORDS));
   // A full region rejects any further bundle, whatever its fields.
   assign bundle_err = overflow ? ERR_OVERFLOW : pack_err;
   // A start seen while a word is still draining waits until the write completes.
   assign start_ok = start && (state != ST_ACTIVE) && !imem_we;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start_ok) state_nxt = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (accept && (bundle_err != ERR_NONE)) state_nxt = ST_ERROR;
            else if (halt_pending && wr_hs)         state_nxt = ST_DONE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         imem_we      <= 1'b0;
         imem_addr    <= 16'h0000;
         imem_wdata   <= 16'h0000;
         word_count   <= 16'h0000;
         acc_count    <= 17'd0;
         halt_pending <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         err_code     <= ERR_NONE;
      end else if (start_ok) begin
         imem_addr    <= base_addr;
         word_count   <= 16'h0000;
         acc_count    <= 17'd0;
         halt_pending <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         err_code     <= ERR_NONE;
      end else begin
         if (wr_hs) begin
            imem_we    <= 1'b0;
            imem_addr  <= imem_addr + 16'd2;
            word_count <= word_count + 16'd1;
            if (halt_pending) begin
               halt_pending <= 1'b0;
               done         <= 1'b1;
            end
         end
         // Placed after the handshake so a same-cycle accept refills the register.
         if (accept) begin
            if (bundle_err != ERR_NONE) begin
               error    <= 1'b1;
               err_code <= bundle_err;
            end else begin
               imem_we    <= 1'b1;
               imem_wdata <= pack_word;
               acc_count  <= acc_count + 17'd1;
               if (in_opcode == OP_HLT) halt_pending <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (DEPTH_WORDS = 4).
// Table of known encodings, hand-written stall/error/overflow/reset sequences,
// then random programs with random imem_ready checked against a program-level model.
module tb_instr_encoder;

   localparam int DEPTH = 4;

   typedef struct {
      logic [3:0]  op;
      logic [3:0]  rd;
      logic [3:0]  rs;
      logic [3:0]  rt;
      logic [15:0] imm;
      logic [2:0]  cond;
   } bundle_t;

   typedef struct {
      bundle_t     b;
      logic [15:0] exp_word;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] base_addr;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_opcode, in_rd, in_rs, in_rt;
   logic [15:0] in_imm;
   logic [2:0]  in_cond;
   logic        imem_we;
   logic        imem_ready;
   logic [15:0] imem_addr, imem_wdata;
   logic        done, error;
   logic [1:0]  err_code;
   logic [15:0] word_count;

   logic        rand_ready = 1'b0;
   logic        ready_man  = 1'b1;
   logic        rnd_bit    = 1'b1;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cap_base;
   logic [31:0] cap_q[$];
   bundle_t     prog_q[$];
   vec_t        vecs[12];

   instr_encoder #(.DEPTH_WORDS(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_opcode  (in_opcode),
      .in_rd      (in_rd),
      .in_rs      (in_rs),
      .in_rt      (in_rt),
      .in_imm     (in_imm),
      .in_cond    (in_cond),
      .imem_we    (imem_we),
      .imem_ready (imem_ready),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .done       (done),
      .error      (error),
      .err_code   (err_code),
      .word_count (word_count)
   );

   initial forever #5 clk = ~clk;

   assign imem_ready = rand_ready ? rnd_bit : ready_man;

   always @(posedge clk) begin
      #1;
      rnd_bit = ($urandom_range(0, 3) != 0);
   end

   // Record every write handshake; inputs are stable at the falling edge.
   always @(negedge clk) begin
      if (!rst && imem_we && imem_ready) cap_q.push_back({imem_addr, imem_wdata});
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic bundle_t mk(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                                  input logic [3:0] rt, input logic [15:0] imm, input logic [2:0] cond);
      bundle_t b;
      b.op = op; b.rd = rd; b.rs = rs; b.rt = rt; b.imm = imm; b.cond = cond;
      return b;
   endfunction

   // Reference encoder written from the ISA field rules with integer arithmetic.
   function automatic void enc(input bundle_t b, output int err, output int word);
      int s, op;
      s = int'($signed(b.imm));
      op = int'(b.op);
      err = 0;
      word = 0;
      if (op <= 3 || op == 7) begin
         word = op * 4096 + int'(b.rd) * 256 + int'(b.rs) * 16 + int'(b.rt);
      end else if (op <= 6) begin
         if (s < 0 || s > 15) err = 1;
         word = op * 4096 + int'(b.rd) * 256 + int'(b.rs) * 16 + (s & 15);
      end else if (op == 8 || op == 9) begin
         if (s % 2 != 0) err = 2;
         else if (s < -16 || s > 14) err = 1;
         word = op * 4096 + (op == 8 ? int'(b.rd) : int'(b.rt)) * 256 + int'(b.rs) * 16 + ((s / 2) & 15);
      end else if (op == 10 || op == 11) begin
         if (s < 0 || s > 255) err = 1;
         word = op * 4096 + int'(b.rd) * 256 + (s & 255);
      end else if (op == 12) begin
         if (s % 2 != 0) err = 2;
         else if (s < -512 || s > 510) err = 1;
         word = op * 4096 + int'(b.cond) * 512 + ((s / 2) & 511);
      end else if (op == 13) begin
         word = op * 4096 + int'(b.cond) * 512 + int'(b.rs) * 16;
      end else if (op == 14) begin
         word = op * 4096 + int'(b.rd) * 256;
      end else begin
         word = 16'hF000;
      end
   endfunction

   task automatic send(input bundle_t b, output bit ok);
      in_valid = 1'b1;
      in_opcode = b.op; in_rd = b.rd; in_rs = b.rs; in_rt = b.rt; in_imm = b.imm; in_cond = b.cond;
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         @(posedge clk);
         #1;
      end else begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: in_ready stayed 0, required 1");
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (!imem_we) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: imem_we stayed 1, required 0");
      end
   endtask

   task automatic pulse_start(input logic [15:0] base);
      start = 1'b1;
      base_addr = base;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Runs prog_q as one program from base and checks the writes and final status.
   task automatic run_prog(input logic [15:0] base);
      logic [31:0] exp_q[$];
      int acc, ecode, e, w, last, got;
      bit halted, ok;
      acc = 0; ecode = 0; halted = 1'b0; last = prog_q.size() - 1;
      for (int i = 0; i < prog_q.size(); i++) begin
         if (acc == DEPTH) begin
            ecode = 3; last = i; break;
         end
         enc(prog_q[i], e, w);
         if (e != 0) begin
            ecode = e; last = i; break;
         end
         exp_q.push_back({16'(int'(base) + 2 * acc), 16'(w)});
         acc++;
         if (prog_q[i].op == 4'hF) begin
            halted = 1'b1; last = i; break;
         end
      end
      cap_base = cap_q.size();
      pulse_start(base);
      chk("start_clears_error", {31'd0, error}, 32'd0);
      chk("start_clears_code", {30'd0, err_code}, 32'd0);
      chk("start_clears_count", {16'd0, word_count}, 32'd0);
      for (int i = 0; i <= last; i++) begin
         send(prog_q[i], ok);
         if (!ok) break;
      end
      wait_idle();
      got = cap_q.size() - cap_base;
      chk("write_count", got, exp_q.size());
      for (int i = 0; i < got && i < exp_q.size(); i++)
         chk("write_addr_data", cap_q[cap_base + i], exp_q[i]);
      chk("done", {31'd0, done}, {31'd0, halted});
      chk("error", {31'd0, error}, (ecode != 0) ? 32'd1 : 32'd0);
      chk("err_code", {30'd0, err_code}, ecode);
      chk("word_count", {16'd0, word_count}, acc);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] rnd_imm();
      int v;
      case ($urandom_range(0, 3))
         0:       v = int'($urandom_range(0, 65535));
         1:       v = int'($urandom_range(0, 40)) - 20;
         2:       v = int'($urandom_range(0, 300));
         default: v = int'($urandom_range(0, 1040)) - 520;
      endcase
      return 16'(v);
   endfunction

   initial begin
      bit ok;
      bundle_t hlt;
      hlt = mk(4'hF, 4'h0, 4'h0, 4'h0, 16'h0000, 3'd0);

      vecs[0]  = '{mk(4'h0, 4'h3, 4'h1, 4'h2, 16'h0000, 3'd0), 16'h0312};
      vecs[1]  = '{mk(4'h8, 4'h4, 4'h5, 4'h0, 16'hFFFC, 3'd0), 16'h845E};
      vecs[2]  = '{mk(4'h9, 4'h0, 4'h2, 4'h7, 16'h0006, 3'd0), 16'h9723};
      vecs[3]  = '{mk(4'hC, 4'h0, 4'h0, 4'h0, 16'hFFFE, 3'd2), 16'hC5FF};
      vecs[4]  = '{mk(4'h4, 4'h1, 4'h2, 4'h0, 16'h000F, 3'd0), 16'h412F};
      vecs[5]  = '{mk(4'hA, 4'h5, 4'h0, 4'h0, 16'h00AB, 3'd0), 16'hA5AB};
      vecs[6]  = '{mk(4'hD, 4'h0, 4'h9, 4'h0, 16'h0000, 3'd7), 16'hDE90};
      vecs[7]  = '{mk(4'hE, 4'h6, 4'h0, 4'h0, 16'h0000, 3'd0), 16'hE600};
      vecs[8]  = '{mk(4'hC, 4'h0, 4'h0, 4'h0, 16'd510, 3'd0), 16'hC0FF};
      vecs[9]  = '{mk(4'hC, 4'h0, 4'h0, 4'h0, 16'hFE00, 3'd0), 16'hC100};
      vecs[10] = '{mk(4'h8, 4'h0, 4'h0, 4'h0, 16'd14, 3'd0), 16'h8007};
      vecs[11] = '{mk(4'h8, 4'h0, 4'h0, 4'h0, 16'hFFF0, 3'd0), 16'h8008};

      rst = 1'b1; start = 1'b0; base_addr = 16'h0000; in_valid = 1'b0;
      in_opcode = 4'h0; in_rd = 4'h0; in_rs = 4'h0; in_rt = 4'h0; in_imm = 16'h0000; in_cond = 3'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_error", {31'd0, error}, 32'd0);
      chk("rst_imem_addr", {16'd0, imem_addr}, 32'd0);
      chk("rst_imem_wdata", {16'd0, imem_wdata}, 32'd0);
      chk("rst_err_code", {30'd0, err_code}, 32'd0);
      chk("rst_word_count", {16'd0, word_count}, 32'd0);
      @(posedge clk);
      #1;

      // Stalled middle word: ADD, SUB, HLT from base 0 with imem_ready low 3 cycles on word 2.
      cap_base = cap_q.size();
      pulse_start(16'h0000);
      send(mk(4'h0, 4'h3, 4'h1, 4'h2, 16'h0000, 3'd0), ok);
      wait_idle();
      chk("first_word_count", {16'd0, word_count}, 32'd1);
      chk("first_write_count", cap_q.size() - cap_base, 32'd1);
      if (cap_q.size() > cap_base) chk("first_write", cap_q[cap_base], 32'h0000_0312);
      @(posedge clk);
      #1 ready_man = 1'b0;
      send(mk(4'h1, 4'h1, 4'h2, 4'h3, 16'h0000, 3'd0), ok);
      in_valid = 1'b1; in_opcode = 4'hF;
      start = 1'b1; base_addr = 16'h5000;   // must be ignored while ACTIVE
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
         chk("stall_we", {31'd0, imem_we}, 32'd1);
         chk("stall_addr", {16'd0, imem_addr}, 32'h0002);
         chk("stall_wdata", {16'd0, imem_wdata}, 32'h1123);
         @(posedge clk);
         #1 start = 1'b0;
      end
      ready_man = 1'b1;
      send(hlt, ok);
      wait_idle();
      chk("halt_done", {31'd0, done}, 32'd1);
      chk("halt_word_count", {16'd0, word_count}, 32'd3);
      chk("halt_write_count", cap_q.size() - cap_base, 32'd3);
      if (cap_q.size() >= cap_base + 3) begin
         chk("halt_sub_write", cap_q[cap_base + 1], 32'h0002_1123);
         chk("halt_hlt_write", cap_q[cap_base + 2], 32'h0004_F000);
      end
      @(posedge clk);
      #1;

      // Table of known encodings, each as a two-word program ending in HLT.
      foreach (vecs[i]) begin
         prog_q = {};
         prog_q.push_back(vecs[i].b);
         prog_q.push_back(hlt);
         run_prog(16'h1000 + 16'(i * 16));
         if (cap_q.size() > cap_base) chk($sformatf("table_%0d", i), {16'd0, cap_q[cap_base][15:0]}, {16'd0, vecs[i].exp_word});
      end

      // Range error, then alignment error; the following start must clear them.
      prog_q = {};
      prog_q.push_back(mk(4'hA, 4'h1, 4'h0, 4'h0, 16'h01FF, 3'd0));
      prog_q.push_back(hlt);
      run_prog(16'h2000);
      chk("llb_range_code", {30'd0, err_code}, 32'd1);
      chk("llb_no_write", cap_q.size() - cap_base, 32'd0);
      prog_q = {};
      prog_q.push_back(mk(4'h8, 4'h1, 4'h2, 4'h0, 16'h0003, 3'd0));
      prog_q.push_back(hlt);
      run_prog(16'h2100);
      chk("lw_align_code", {30'd0, err_code}, 32'd2);

      // Region overflow: five ADDs into a four-word region.
      prog_q = {};
      for (int i = 0; i < 5; i++) prog_q.push_back(mk(4'h0, 4'(i), 4'h1, 4'h2, 16'h0000, 3'd0));
      run_prog(16'h3000);
      chk("ovf_code", {30'd0, err_code}, 32'd3);
      chk("ovf_writes", cap_q.size() - cap_base, 32'd4);

      // Reset during a stalled write drops it; restart at a new base.
      ready_man = 1'b0;
      cap_base = cap_q.size();
      pulse_start(16'h0200);
      send(mk(4'h0, 4'h7, 4'h7, 4'h7, 16'h0000, 3'd0), ok);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("rstmid_we", {31'd0, imem_we}, 32'd0);
      chk("rstmid_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rstmid_addr", {16'd0, imem_addr}, 32'd0);
      ready_man = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rstmid_idle", {31'd0, in_ready}, 32'd0);
      chk("rstmid_dropped", cap_q.size() - cap_base, 32'd0);
      @(posedge clk);
      #1;
      prog_q = {};
      prog_q.push_back(mk(4'h2, 4'h1, 4'h2, 4'h3, 16'h0000, 3'd0));
      prog_q.push_back(hlt);
      run_prog(16'h0300);

      // Random programs with random memory backpressure.
      rand_ready = 1'b1;
      for (int p = 0; p < 40; p++) begin
         int n;
         logic [15:0] base;
         prog_q = {};
         n = int'($urandom_range(1, 6));
         for (int j = 0; j < n; j++) begin
            bundle_t b;
            b = mk(4'($urandom_range(0, 14)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), rnd_imm(), 3'($urandom_range(0, 7)));
            if (j == n - 1) b.op = 4'hF;
            prog_q.push_back(b);
         end
         base = ($urandom_range(0, 3) == 0) ? 16'hFFFC : (16'($urandom()) & 16'hFFFE);
         run_prog(base);
      end
      rand_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the instruction decoder: accepts per-instruction fields (opcode, register indices, byte-valued immediate, branch condition) over a valid/ready handshake.
- Range-checks and packs the fields into a 16-bit instruction word, then streams the words sequentially into instruction memory.
- Used as the program loader and self-check path, so that encode(fields) followed by decode reproduces the fields.

Parameters:
- DEPTH_WORDS, 256, number of 16-bit words the program region holds, starting at base_addr.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  pulse: begin a new program at base_addr; honoured only in IDLE/DONE/ERROR.
- base_addr  in  16  byte address of the first word; bit 0 must be 0; sampled on start.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  field bundle accepted when in_valid && in_ready.
- in_opcode  in  4  ISA opcode 0x0 through 0xF.
- in_rd  in  4  destination register.
- in_rs  in  4  source register 1.
- in_rt  in  4  source register 2; for SW, the data register.
- in_imm  in  16  signed immediate in bytes (LW/SW/B) or raw value (shift/LLB/LHB).
- in_cond  in  3  branch condition for B/BR.
- imem_we  out  1  write strobe (valid).
- imem_ready  in  1  memory accepts the write this cycle.
- imem_addr  out  16  byte address of the word.
- imem_wdata  out  16  encoded instruction.
- done  out  1  HLT written; sticky until next start.
- error  out  1  sticky until next start.
- err_code  out  2  0 none, 1 immediate out of range, 2 immediate misaligned, 3 region overflow.
- word_count  out  16  words written since start.

Behaviour:
- Reset: state IDLE; in_ready, imem_we, done and error are 0; imem_addr, imem_wdata, err_code and word_count are 0.
- FSM states: IDLE, ACTIVE, DONE, ERROR.
  - IDLE/DONE/ERROR -> ACTIVE on start. Start loads addr=base_addr, clears count, done, error and err_code.
  - start is ignored while in ACTIVE.
- in_ready = (state==ACTIVE) && (!imem_we || imem_ready) && !halt_pending. Output register depth is one.
- Accept cycle N: the encoded word is registered; imem_we=1 from cycle N+1.
  - imem_addr/imem_wdata are held stable while imem_we && !imem_ready.
  - On a write handshake: addr += 2 (16-bit wrap) and word_count += 1.
  - An accept may coincide with a handshake, giving back-to-back throughput of 1 word/cycle.
- Encoding:
  - 0,1,2,3,7: {op,rd,rs,rt}.
  - 4,5,6: {op,rd,rs,imm[3:0]}; requires 0 <= imm <= 15.
  - 8 (LW): {op,rd,rs,imm[4:1]}. 9 (SW): {op,rt,rs,imm[4:1]}.
    - Requires imm even, else code 2.
    - Requires -16 <= imm <= 14, else code 1.
  - A,B (LLB/LHB): {op,rd,imm[7:0]}; requires 0 <= imm <= 255.
  - C (B): {op,cond,imm[9:1]}; requires imm even and -512 <= imm <= 510.
  - D (BR): {op,cond,1'b0,rs,4'h0}.
  - E (PCS): {op,rd,8'h00}.
  - F (HLT): 16'hF000.
- Check priority: misalignment (2) over range (1).
- Error on an accepted bundle:
  - The bundle is consumed, no word is written, and the state goes to ERROR with err_code set.
  - A word already in the output register still completes its write.
- Overflow: accepting a bundle when the accepted count is already DEPTH_WORDS gives ERROR with code 3; no write.
- HLT accepted: halt_pending=1 and in_ready drops. After its write handshake the state goes to DONE and done=1.
- start arriving with a write still pending in DONE/ERROR: the pending write completes first, and start is honoured only after imem_we=0.
- Reset mid-write drops the pending write; no partial words.

Decomposition:
- Shared ISA package holds:
  - opcode constants OP_ADD..OP_HLT, shared with the decoder;
  - err_code constants;
  - FSM state enum.
- Optional sub-module instr_pack: purely combinational field-to-word plus error check. The FSM and output register stay in instr_encoder.

Test Plan:
- start, base 0x0000; ADD rd3,rs1,rt2 -> write addr 0x0000 data 0x0312; word_count=1.
- LW rd4,rs5,imm=-4 -> 0x845E. SW rt7,rs2,imm=6 -> 0x9723. B cond=2,imm=-2 -> 0xC5FF.
- ADD, SUB, HLT with imem_ready low 3 cycles on word 2:
  - in_ready=0 and addr 0x0002 / wdata held while stalled;
  - then HLT written at 0x0004 as 0xF000;
  - done=1, word_count=3.
- LLB imm=0x1FF -> no write, error=1, err_code=1. LW imm=3 -> err_code=2. Start clears both.
- DEPTH_WORDS=4: five ADDs -> 4 writes, 5th gives err_code=3 with no fifth imem_we.
- Assert rst during a stalled write -> imem_we=0 immediately, state IDLE, start restarts at the new base_addr.
